// File: rtl/tartaruga_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tartaruga_pkg
// Purpose  : Shared types and constants for the post-commit store buffer.
//            Provides the default buffer depth, the pointer type, the
//            buffer entry layout and the RV32 store funct3 encodings.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package tartaruga_pkg;

  // Default number of store buffer entries (power of two, >= 2).
  localparam int SB_SIZE = 4;

  typedef logic [$clog2(SB_SIZE)-1:0] sb_idx_t;

  // One buffered store: word address, lane-aligned data and byte strobe.
  typedef struct packed {
    logic        valid;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } sb_entry_t;

  // RV32 store funct3 encodings (instr[14:12]).
  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;

endpackage
`default_nettype wire

// File: rtl/sb_store_align.sv
`default_nettype none
// ============================================================================
// Module   : sb_store_align
// Purpose  : Combinational store formatter. Turns an RV32 store (funct3,
//            low address bits, raw rs2 data) into lane-shifted data and a
//            4-bit byte strobe, and flags misaligned or non-store encodings.
// Ports    : funct3     in  3   store width encoding
//            addr_lo    in  2   effective address bits [1:0]
//            data       in  32  rs2 data, unshifted
//            data_out   out 32  data shifted into its byte lanes, other lanes 0
//            strb       out 4   byte enables (0 when misaligned)
//            misaligned out 1   store cannot be buffered
// Revision : 1.0 - initial release
// ============================================================================
module sb_store_align
  import tartaruga_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [31:0] data_out,
  output logic [3:0]  strb,
  output logic        misaligned
);

  logic [31:0] shifted;
  logic [31:0] lane_mask;

  always_comb begin
    strb       = 4'b0000;
    misaligned = 1'b0;
    case (funct3)
      F3_SB: strb = 4'b0001 << addr_lo;
      F3_SH: begin
        if (addr_lo[0]) misaligned = 1'b1;
        else            strb       = 4'b0011 << addr_lo;
      end
      F3_SW: begin
        if (addr_lo != 2'b00) misaligned = 1'b1;
        else                  strb       = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign shifted = data << {addr_lo, 3'b000};

  // Lanes outside the strobe are forced to zero so stale upper bytes of rs2
  // never reach memory or the forwarding path.
  generate
    for (genvar i = 0; i < 4; i++) begin : g_lane
      assign lane_mask[8*i +: 8] = {8{strb[i]}};
    end
  endgenerate

  assign data_out = shifted & lane_mask;

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : store_buffer
// Purpose  : Post-commit store queue. Accepts committed RV32 stores from the
//            ROB commit port and drains them strictly in order to data memory
//            over a valid/ready write channel. Only reset clears it.
// Config   : `define SB_FWD_EN adds a combinational store-to-load forwarding
//            lookup (fwd_addr_i / fwd_hit_o / fwd_data_o / fwd_strb_o).
// Ports    : clk_i, rstn_i (async, active-low)
//            commit_valid_i/store_i/instr_i/addr_i/data_i  commit beat
//            commit_ready_o   buffer can accept a store this cycle
//            misaligned_o     one-cycle pulse after a rejected store
//            mem_req_valid_o/ready_i/addr_o/data_o/strb_o  write channel
//            count_o, empty_o occupancy
//            fwd_*            forwarding lookup (SB_FWD_EN only)
// Revision : 1.0 - initial release
// ============================================================================
module store_buffer
  import tartaruga_pkg::*;
#(
  parameter int SB_SIZE  = tartaruga_pkg::SB_SIZE,
  parameter int SB_IDX_W = $clog2(SB_SIZE)
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                commit_valid_i,
  input  logic                commit_store_i,
  input  logic [31:0]         commit_instr_i,
  input  logic [31:0]         commit_addr_i,
  input  logic [31:0]         commit_data_i,
  output logic                commit_ready_o,
  output logic                misaligned_o,
  output logic                mem_req_valid_o,
  input  logic                mem_req_ready_i,
  output logic [31:0]         mem_req_addr_o,
  output logic [31:0]         mem_req_data_o,
  output logic [3:0]          mem_req_strb_o,
  output logic [SB_IDX_W:0]   count_o,
`ifdef SB_FWD_EN
  input  logic [31:0]         fwd_addr_i,
  output logic                fwd_hit_o,
  output logic [31:0]         fwd_data_o,
  output logic [3:0]          fwd_strb_o,
`endif
  output logic                empty_o
);

  sb_entry_t             entries [SB_SIZE];
  sb_entry_t             head_entry;
  logic [SB_IDX_W-1:0]   head;
  logic [SB_IDX_W-1:0]   tail;
  logic [SB_IDX_W:0]     count;
  logic                  misaligned_q;

  logic [31:0]           al_data;
  logic [3:0]            al_strb;
  logic                  al_mis;

  logic                  store_beat;
  logic                  enq;
  logic                  deq;

  sb_store_align u_align (
    .funct3     (commit_instr_i[14:12]),
    .addr_lo    (commit_addr_i[1:0]),
    .data       (commit_data_i),
    .data_out   (al_data),
    .strb       (al_strb),
    .misaligned (al_mis)
  );

  // Acceptance uses registered occupancy only: a dequeue in the same cycle
  // does not free a slot until the next cycle.
  assign commit_ready_o = (count < (SB_IDX_W+1)'(SB_SIZE));

  // A store beat is consumed only when the buffer is ready; while not ready
  // the ROB holds it, so a misaligned store is reported once, on acceptance.
  assign store_beat = commit_valid_i & commit_store_i & commit_ready_o;
  assign enq        = store_beat & ~al_mis;

  assign head_entry      = entries[head];
  assign mem_req_valid_o = (count != '0);
  assign deq             = mem_req_valid_o & mem_req_ready_i;

  // The request fields come straight from the registered head entry, so they
  // stay stable while the request is stalled.
  assign mem_req_addr_o = mem_req_valid_o ? {head_entry.addr, 2'b00} : 32'h0;
  assign mem_req_data_o = mem_req_valid_o ? head_entry.data : 32'h0;
  assign mem_req_strb_o = mem_req_valid_o ? head_entry.strb : 4'h0;

  assign count_o      = count;
  assign empty_o      = (count == '0);
  assign misaligned_o = misaligned_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      misaligned_q <= 1'b0;
      for (int i = 0; i < SB_SIZE; i++) begin
        entries[i] <= '0;
      end
    end else begin
      misaligned_q <= store_beat & al_mis;

      // When enqueue and dequeue coincide the buffer is neither empty nor
      // full, so head and tail address different slots.
      if (enq) begin
        entries[tail] <= '{valid: 1'b1,
                           addr:  commit_addr_i[31:2],
                           data:  al_data,
                           strb:  al_strb};
        tail <= tail + 1'b1;
      end
      if (deq) begin
        entries[head].valid <= 1'b0;
        head <= head + 1'b1;
      end

      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef SB_FWD_EN
  // Entries reordered oldest-first so the lookup loop lets younger stores
  // overwrite older ones byte by byte.
  sb_entry_t aged [SB_SIZE];

  generate
    for (genvar k = 0; k < SB_SIZE; k++) begin : g_age
      assign aged[k] = entries[head + SB_IDX_W'(k)];
    end
  endgenerate

  always_comb begin
    fwd_data_o = 32'h0;
    fwd_strb_o = 4'h0;
    for (int k = 0; k < SB_SIZE; k++) begin
      if (aged[k].valid && (aged[k].addr == fwd_addr_i[31:2])) begin
        for (int b = 0; b < 4; b++) begin
          if (aged[k].strb[b]) begin
            fwd_data_o[8*b +: 8] = aged[k].data[8*b +: 8];
          end
        end
        fwd_strb_o = fwd_strb_o | aged[k].strb;
      end
    end
  end

  assign fwd_hit_o = |fwd_strb_o;

  logic unused_bits;
  assign unused_bits = ^{commit_instr_i[31:15], commit_instr_i[11:0],
                         head_entry.valid, fwd_addr_i[1:0]};
`else
  logic unused_bits;
  assign unused_bits = ^{commit_instr_i[31:15], commit_instr_i[11:0],
                         head_entry.valid};
`endif

endmodule
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_buffer
// Purpose  : Self-checking bench for store_buffer. Directed stores push their
//            hand-computed memory beats into a scoreboard queue; a monitor
//            pops and compares on every write handshake and checks that a
//            stalled request stays stable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_buffer;
  import tartaruga_pkg::*;

  localparam int DEPTH = 4;
  localparam int IW    = 2;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b0;
  logic          commit_valid_i = 1'b0;
  logic          commit_store_i = 1'b0;
  logic [31:0]   commit_instr_i = '0;
  logic [31:0]   commit_addr_i = '0;
  logic [31:0]   commit_data_i = '0;
  logic          commit_ready_o;
  logic          misaligned_o;
  logic          mem_req_valid_o;
  logic          mem_req_ready_i = 1'b0;
  logic [31:0]   mem_req_addr_o;
  logic [31:0]   mem_req_data_o;
  logic [3:0]    mem_req_strb_o;
  logic [IW:0]   count_o;
  logic          empty_o;
`ifdef SB_FWD_EN
  logic [31:0]   fwd_addr_i = '0;
  logic          fwd_hit_o;
  logic [31:0]   fwd_data_o;
  logic [3:0]    fwd_strb_o;
`endif

  always #5 clk_i = ~clk_i;

  store_buffer #(.SB_SIZE(DEPTH), .SB_IDX_W(IW)) dut (
    .clk_i           (clk_i),
    .rstn_i          (rstn_i),
    .commit_valid_i  (commit_valid_i),
    .commit_store_i  (commit_store_i),
    .commit_instr_i  (commit_instr_i),
    .commit_addr_i   (commit_addr_i),
    .commit_data_i   (commit_data_i),
    .commit_ready_o  (commit_ready_o),
    .misaligned_o    (misaligned_o),
    .mem_req_valid_o (mem_req_valid_o),
    .mem_req_ready_i (mem_req_ready_i),
    .mem_req_addr_o  (mem_req_addr_o),
    .mem_req_data_o  (mem_req_data_o),
    .mem_req_strb_o  (mem_req_strb_o),
    .count_o         (count_o),
`ifdef SB_FWD_EN
    .fwd_addr_i      (fwd_addr_i),
    .fwd_hit_o       (fwd_hit_o),
    .fwd_data_o      (fwd_data_o),
    .fwd_strb_o      (fwd_strb_o),
`endif
    .empty_o         (empty_o)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  beat_t exp_q[$];
  int    n_pass  = 0;
  int    n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, act, req, $time);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: scoreboard compare on handshake, stability while stalled.
  // --------------------------------------------------------------------------
  logic  stall_prev = 1'b0;
  beat_t held;
  beat_t exp_b;

  initial begin
    forever begin
      @(negedge clk_i);
      if (!rstn_i) begin
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) begin
          chk("held_valid", 32'(mem_req_valid_o), 32'd1);
          chk("held_addr",  mem_req_addr_o, held.addr);
          chk("held_data",  mem_req_data_o, held.data);
          chk("held_strb",  32'(mem_req_strb_o), 32'(held.strb));
        end
        if (mem_req_valid_o && mem_req_ready_i) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_beat", 32'(mem_req_valid_o), 32'd0);
          end else begin
            exp_b = exp_q.pop_front();
            chk("beat_addr", mem_req_addr_o, exp_b.addr);
            chk("beat_data", mem_req_data_o, exp_b.data);
            chk("beat_strb", 32'(mem_req_strb_o), 32'(exp_b.strb));
          end
        end
        stall_prev = mem_req_valid_o && !mem_req_ready_i;
        held       = '{mem_req_addr_o, mem_req_data_o, mem_req_strb_o};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus helpers
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_commit(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    commit_valid_i = 1'b1;
    commit_store_i = 1'b1;
    commit_instr_i = {17'h0, f3, 5'h0, 7'h23};
    commit_addr_i  = a;
    commit_data_i  = d;
  endtask

  task automatic clr_commit();
    commit_valid_i = 1'b0;
    commit_store_i = 1'b0;
  endtask

  // Issue one store, waiting (bounded) for commit_ready_o; when ok is set the
  // hand-computed memory beat is queued for the monitor.
  task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                          input logic ok, input logic [31:0] ea, input logic [31:0] ed,
                          input logic [3:0] es);
    int n = 0;
    set_commit(f3, a, d);
    while (!commit_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("commit_ready_timeout", 32'(commit_ready_o), 32'd1);
    if (ok) exp_q.push_back('{ea, ed, es});
    tick();
    clr_commit();
  endtask

  task automatic wait_empty(input string name);
    int n = 0;
    while (!empty_o && n < 100) begin
      tick();
      n++;
    end
    chk(name, 32'(empty_o), 32'd1);
  endtask

  // --------------------------------------------------------------------------
  // Directed sequence
  // --------------------------------------------------------------------------
  initial begin
    tick();
    tick();
    chk("rst_count",      32'(count_o), 32'd0);
    chk("rst_empty",      32'(empty_o), 32'd1);
    chk("rst_ready",      32'(commit_ready_o), 32'd1);
    chk("rst_valid",      32'(mem_req_valid_o), 32'd0);
    chk("rst_addr",       mem_req_addr_o, 32'h0);
    chk("rst_data",       mem_req_data_o, 32'h0);
    chk("rst_strb",       32'(mem_req_strb_o), 32'h0);
    chk("rst_misaligned", 32'(misaligned_o), 32'd0);
    rstn_i = 1'b1;
    tick();

    // SW with ready high: no bypass, valid one cycle after the commit edge.
    mem_req_ready_i = 1'b1;
    set_commit(F3_SW, 32'h0000_1000, 32'hDEAD_BEEF);
    exp_q.push_back('{32'h0000_1000, 32'hDEAD_BEEF, 4'b1111});
    chk("sw_no_bypass", 32'(mem_req_valid_o), 32'd0);
    tick();
    clr_commit();
    chk("sw_valid_lat1", 32'(mem_req_valid_o), 32'd1);
    chk("sw_count",      32'(count_o), 32'd1);
    tick();
    chk("sw_empty_after", 32'(empty_o), 32'd1);

    // SB into the top lane.
    do_store(F3_SB, 32'h0000_1003, 32'h0000_00AB, 1'b1, 32'h0000_1000, 32'hAB00_0000, 4'b1000);
    tick();
    chk("sb_empty_after", 32'(empty_o), 32'd1);

    // Misaligned SH: single pulse, nothing enqueued.
    do_store(F3_SH, 32'h0000_1001, 32'h0000_BEEF, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("sh_mis_pulse", 32'(misaligned_o), 32'd1);
    chk("sh_mis_count", 32'(count_o), 32'd0);
    chk("sh_mis_ready", 32'(commit_ready_o), 32'd1);
    tick();
    chk("sh_mis_clear", 32'(misaligned_o), 32'd0);

    // Unsupported funct3 is rejected too.
    do_store(3'b011, 32'h0000_1000, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 4'h0);
    chk("f3_bad_pulse", 32'(misaligned_o), 32'd1);
    chk("f3_bad_count", 32'(count_o), 32'd0);

    // Non-store commit beat is ignored.
    set_commit(F3_SW, 32'h0000_1000, 32'h1234_5678);
    commit_store_i = 1'b0;
    tick();
    clr_commit();
    chk("nonstore_count", 32'(count_o), 32'd0);
    chk("nonstore_mis",   32'(misaligned_o), 32'd0);

    // Backpressure: fill to full.
    mem_req_ready_i = 1'b0;
    do_store(F3_SW, 32'h0000_0100, 32'h1111_1111, 1'b1, 32'h0000_0100, 32'h1111_1111, 4'b1111);
    do_store(F3_SW, 32'h0000_0104, 32'h2222_2222, 1'b1, 32'h0000_0104, 32'h2222_2222, 4'b1111);
    do_store(F3_SW, 32'h0000_0108, 32'h3333_3333, 1'b1, 32'h0000_0108, 32'h3333_3333, 4'b1111);
    do_store(F3_SW, 32'h0000_010C, 32'h4444_4444, 1'b1, 32'h0000_010C, 32'h4444_4444, 4'b1111);
    chk("full_count", 32'(count_o), 32'd4);
    chk("full_ready", 32'(commit_ready_o), 32'd0);
    chk("full_head",  mem_req_addr_o, 32'h0000_0100);
    tick();
    tick();

    // Fifth store waits for the cycle after the first dequeue.
    set_commit(F3_SW, 32'h0000_0110, 32'h5555_5555);
    exp_q.push_back('{32'h0000_0110, 32'h5555_5555, 4'b1111});
    tick();
    chk("full_hold_count", 32'(count_o), 32'd4);
    mem_req_ready_i = 1'b1;
    tick();
    chk("deq_full_count", 32'(count_o), 32'd3);
    chk("deq_full_ready", 32'(commit_ready_o), 32'd1);
    tick();
    clr_commit();
    chk("fifth_enq_count", 32'(count_o), 32'd3);
    tick();
    tick();
    tick();
    chk("drain_consecutive", 32'(empty_o), 32'd1);

    // Simultaneous enqueue and dequeue at count=2.
    mem_req_ready_i = 1'b0;
    do_store(F3_SW, 32'h0000_0200, 32'hCAFE_F00D, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 4'b1111);
    do_store(F3_SW, 32'h0000_0204, 32'h0BAD_F00D, 1'b1, 32'h0000_0204, 32'h0BAD_F00D, 4'b1111);
    chk("two_count", 32'(count_o), 32'd2);
    set_commit(F3_SH, 32'h0000_0206, 32'h0000_1234);
    exp_q.push_back('{32'h0000_0204, 32'h1234_0000, 4'b1100});
    mem_req_ready_i = 1'b1;
    tick();
    clr_commit();
    chk("enq_deq_count", 32'(count_o), 32'd2);
    tick();
    tick();
    chk("enq_deq_empty", 32'(empty_o), 32'd1);

    // Reset mid-drain with three entries left.
    mem_req_ready_i = 1'b0;
    do_store(F3_SW, 32'h0000_0300, 32'hAAAA_0001, 1'b1, 32'h0000_0300, 32'hAAAA_0001, 4'b1111);
    do_store(F3_SW, 32'h0000_0304, 32'hAAAA_0002, 1'b1, 32'h0000_0304, 32'hAAAA_0002, 4'b1111);
    do_store(F3_SW, 32'h0000_0308, 32'hAAAA_0003, 1'b1, 32'h0000_0308, 32'hAAAA_0003, 4'b1111);
    do_store(F3_SW, 32'h0000_030C, 32'hAAAA_0004, 1'b1, 32'h0000_030C, 32'hAAAA_0004, 4'b1111);
    mem_req_ready_i = 1'b1;
    tick();
    chk("mid_drain_count", 32'(count_o), 32'd3);
    #2;
    rstn_i = 1'b0;
    #1;
    chk("async_rst_valid", 32'(mem_req_valid_o), 32'd0);
    chk("async_rst_count", 32'(count_o), 32'd0);
    chk("async_rst_ready", 32'(commit_ready_o), 32'd1);
    exp_q.delete();
    tick();
    rstn_i = 1'b1;
    tick();
    chk("post_rst_empty", 32'(empty_o), 32'd1);

`ifdef SB_FWD_EN
    // Forwarding: younger SB overrides one byte of an older SW.
    mem_req_ready_i = 1'b0;
    do_store(F3_SW, 32'h0000_2000, 32'h1122_3344, 1'b1, 32'h0000_2000, 32'h1122_3344, 4'b1111);
    do_store(F3_SB, 32'h0000_2001, 32'h0000_0055, 1'b1, 32'h0000_2000, 32'h0000_5500, 4'b0010);
    fwd_addr_i = 32'h0000_2002;
    #1;
    chk("fwd_hit",  32'(fwd_hit_o), 32'd1);
    chk("fwd_data", fwd_data_o, 32'h1122_5544);
    chk("fwd_strb", 32'(fwd_strb_o), 32'hF);
    fwd_addr_i = 32'h0000_3000;
    #1;
    chk("fwd_miss_hit",  32'(fwd_hit_o), 32'd0);
    chk("fwd_miss_data", fwd_data_o, 32'h0);
    tick();
    mem_req_ready_i = 1'b1;
`endif

    mem_req_ready_i = 1'b1;
    wait_empty("final_empty");
    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Post-commit store queue. Accepts architecturally committed stores from the ROB commit port and drains them in order to data memory over a valid/ready write channel.
- Converts RV32 SB/SH/SW into a word-aligned address, lane-shifted data and a 4-bit byte strobe.
- Committed stores are architectural, so branch flush never touches this block. Only reset clears it.

Parameters:
SB_SIZE, 4, entry count; power of two, >= 2
SB_IDX_W, $clog2(SB_SIZE), pointer width

Ports:
clk_i  in  1  clock
rstn_i  in  1  reset
commit_valid_i  in  1  ROB commit beat valid
commit_store_i  in  1  committed instr is a store
commit_instr_i  in  32  committed instruction_t; funct3 = instr[14:12]
commit_addr_i  in  32  effective byte address
commit_data_i  in  32  rs2 store data, unshifted
commit_ready_o  out  1  buffer can accept; ROB holds its head entry while low
misaligned_o  out  1  one-cycle pulse: rejected store
mem_req_valid_o  out  1  write request valid
mem_req_ready_i  in  1  memory accepts write
mem_req_addr_o  out  32  word address, [1:0]=0
mem_req_data_o  out  32  lane-aligned data
mem_req_strb_o  out  4  byte enables
count_o  out  SB_IDX_W+1  occupied entries
empty_o  out  1  count_o==0

Behaviour:
- Interface: reset rstn_i, asynchronous, active-low; clock clk_i.
- Reset values: head=tail=0; all entries invalid; count_o=0; empty_o=1; commit_ready_o=1; mem_req_valid_o=0; mem_req_addr_o, mem_req_data_o and mem_req_strb_o all 0; misaligned_o=0.
- Enqueue condition: commit_valid_i & commit_store_i & commit_ready_o & aligned. Takes effect at the rising edge.
- Non-store commit beats are ignored.
- commit_ready_o = (count_o < SB_SIZE). Registered occupancy only; no same-cycle dequeue credit.
- Alignment and strobe, by funct3:
  - 000 SB: strb = 0001<<a[1:0]; data = d[7:0] replicated to the selected lane.
  - 001 SH: a[0] must be 0; strb = 0011<<a[1:0].
  - 010 SW: a[1:0] must be 00; strb = 1111.
  - Any other funct3, or a misaligned address: not enqueued; misaligned_o=1 in the following cycle only; commit_ready_o unaffected.
- Data shift: data = store data << (8*a[1:0]). Byte lanes outside the strobe are don't-care; drive them 0.
- Drain:
  - mem_req_* show the head entry whenever count>0.
  - Minimum latency enqueue -> mem_req_valid_o is 1 cycle. There is no combinational bypass when empty.
  - Once mem_req_valid_o rises, it and the address/data/strobe stay stable until the mem_req_ready_i handshake.
  - On handshake, head advances. The next entry is presented the following cycle; back-to-back drain gives one entry per cycle.
- Pointers wrap modulo SB_SIZE. count_o is tracked explicitly: +1 on enqueue, -1 on dequeue, unchanged when both happen in the same cycle.
- Boundaries:
  - Full with dequeue in the same cycle: commit_ready_o is still 0 that cycle; rises next cycle.
  - Empty: mem_req_valid_o=0, and mem_req_ready_i is ignored.
  - Reset mid-drain: everything returns to reset values immediately (asynchronous); pending entries are lost.
- Ordering: strict FIFO. No coalescing of stores.

Optional Feature:
- Macro: SB_FWD_EN.
- With SB_FWD_EN, added ports:
  - fwd_addr_i in 32 (load address, bits [1:0] ignored).
  - fwd_hit_o out 1.
  - fwd_data_o out 32.
  - fwd_strb_o out 4.
- Lookup is combinational over valid entries whose word address matches fwd_addr_i. For each byte, the youngest matching entry wins.
- fwd_strb_o = OR of the matching strobes. fwd_hit_o = |fwd_strb_o. Bytes not covered are 0.
- An entry being dequeued in the current cycle still participates.
- Without SB_FWD_EN: no forwarding ports and no comparators.

Decomposition:
- tartaruga_pkg gets:
  - SB_SIZE.
  - sb_idx_t.
  - sb_entry_t {valid, addr[31:2], data[31:0], strb[3:0]}.
  - Store funct3 constants F3_SB/F3_SH/F3_SW.
- One combinational sub-module, sb_store_align. Inputs: funct3, addr[1:0], data. Outputs: shifted data, strb, misaligned.

Test Plan:
- SW a=0x1000 d=0xDEADBEEF, ready=1 -> next cycle one beat: addr 0x1000, data 0xDEADBEEF, strb 1111; then empty_o=1.
- SB a=0x1003 d=0x000000AB -> addr 0x1000, data 0xAB000000, strb 1000.
- SH a=0x1001 -> misaligned_o pulses for 1 cycle; count_o stays 0; no request.
- Backpressure:
  - 4 SW with mem_req_ready_i=0 -> count_o=4, commit_ready_o=0, request held stable.
  - Raise ready -> 4 beats in commit order over 4 consecutive cycles.
- Concurrency:
  - count=2 with simultaneous enqueue and dequeue -> count stays 2.
  - With full, a 5th commit held until the cycle after the first dequeue.
- Reset mid-drain, count=3 -> mem_req_valid_o=0 and count_o=0 immediately.
- SB_FWD_EN:
  - SW 0x2000 d=0x11223344, then SB 0x2001 d=0x55, fwd_addr=0x2002 -> hit=1, data 0x11225544, strb 1111.
  - fwd_addr=0x3000 -> hit=0.
